// File: rtl/fetch_ctrl_pkg.sv
// Shared widths, reset constants, FSM encodings and the fetch-queue payload type
// used by the fetch-stage sequencer and its buffer.
package fetch_ctrl_pkg;

  localparam int PC_WIDTH    = 32;
  localparam int XLEN        = 32;
  localparam int INSTR_WIDTH = 32;

  localparam logic [PC_WIDTH-1:0]    RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR        = 32'h0000_0013;

  localparam logic [0:0] FETCH_BOOT = 1'b0;
  localparam logic [0:0] FETCH_RUN  = 1'b1;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]    pc;
    logic                   pred_taken;
  } fetch_entry_t;

  // Redirect targets may carry junk in the low bits; fetch is always word aligned.
  function automatic logic [PC_WIDTH-1:0] align_pc(input logic [PC_WIDTH-1:0] pc);
    return {pc[PC_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bus: PC_instr fetch/pre-decode side, backend redirect, and F->D queue head.
interface fetch_if;
  import fetch_ctrl_pkg::*;

  logic [PC_WIDTH-1:0]    F_PC_o;
  logic [INSTR_WIDTH-1:0] instr_i;
  logic                   mini_jmp_sel_i;
  logic [XLEN-1:0]        mini_jmp_i;
  logic                   F_commit_i;
  logic                   E_redirect_i;
  logic [PC_WIDTH-1:0]    E_redirect_pc_i;
  logic                   D_ready_i;
  logic                   FD_valid_o;
  logic [INSTR_WIDTH-1:0] FD_instr_o;
  logic [PC_WIDTH-1:0]    FD_pc_o;
  logic                   FD_pred_taken_o;

  modport master (
    output F_PC_o, FD_valid_o, FD_instr_o, FD_pc_o, FD_pred_taken_o,
    input  instr_i, mini_jmp_sel_i, mini_jmp_i, F_commit_i,
           E_redirect_i, E_redirect_pc_i, D_ready_i
  );

  modport slave (
    input  F_PC_o, FD_valid_o, FD_instr_o, FD_pc_o, FD_pred_taken_o,
    output instr_i, mini_jmp_sel_i, mini_jmp_i, F_commit_i,
           E_redirect_i, E_redirect_pc_i, D_ready_i
  );

endinterface

// File: rtl/fetch_buf.sv
// Small synchronous FIFO of fetched instructions with single-cycle flush.
// The head entry is presented straight from the storage registers.
module fetch_buf
  import fetch_ctrl_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fetch_entry_t     push_data,
  output fetch_entry_t     head_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  fetch_entry_t     mem_reg [DEPTH];
  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign do_pop  = pop & ~flush & ~empty;
  assign do_push = push & ~flush & (~full | do_pop);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (rst) begin
          mem_reg[gi] <= '{instr: NOP_INSTR, pc: '0, pred_taken: 1'b0};
        end else if (do_push && tail_reg == PTR_W'(gi)) begin
          mem_reg[gi] <= push_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (do_push) tail_reg <= tail_reg + PTR_W'(1);
      if (do_pop)  head_reg <= head_reg + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head_data = mem_reg[head_reg];
  assign count     = count_reg;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC, selects redirect / pre-decode target /
// PC+4, and queues committed fetches toward decode.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int                  BUF_DEPTH = 2
) (
  input logic       clk,
  input logic       rst,
  fetch_if.master   bus
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  logic [0:0]          state_reg;
  logic [0:0]          state_next;
  logic [PC_WIDTH-1:0] pc_reg;
  logic [PC_WIDTH-1:0] pc_next;
  fetch_entry_t        push_entry;
  fetch_entry_t        head_entry;
  logic                buf_full;
  logic                buf_empty;
  logic [CNT_W-1:0]    buf_count;
  logic                pop;
  logic                fetch_ok;

  assign pop      = ~buf_empty & bus.D_ready_i;
  // A full queue still accepts a fetch when decode drains the head this cycle.
  assign fetch_ok = (state_reg == FETCH_RUN) & bus.F_commit_i & ~bus.E_redirect_i
                  & (~buf_full | pop);

  assign push_entry = '{instr: bus.instr_i, pc: pc_reg, pred_taken: bus.mini_jmp_sel_i};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FETCH_BOOT: state_next = FETCH_RUN;
      default:    state_next = FETCH_RUN;
    endcase
  end

  always_comb begin
    pc_next = pc_reg;
    if (bus.E_redirect_i) begin
      pc_next = align_pc(bus.E_redirect_pc_i);
    end else if (fetch_ok) begin
      pc_next = bus.mini_jmp_sel_i ? bus.mini_jmp_i[PC_WIDTH-1:0] : pc_reg + PC_WIDTH'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= FETCH_BOOT;
      pc_reg    <= RESET_PC;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
    end
  end

  fetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (fetch_ok),
    .pop       (pop),
    .flush     (bus.E_redirect_i),
    .push_data (push_entry),
    .head_data (head_entry),
    .full      (buf_full),
    .empty     (buf_empty),
    .count     (buf_count)
  );

  assign bus.F_PC_o          = pc_reg;
  assign bus.FD_valid_o      = (buf_count != '0);
  assign bus.FD_instr_o      = head_entry.instr;
  assign bus.FD_pc_o         = head_entry.pc;
  assign bus.FD_pred_taken_o = head_entry.pred_taken;

endmodule
